cpu_control_unit: RTL

- Main sequencer of the Mini-CPU. It owns the 3-bit stateCPU bus and walks each instruction through OFF/FETCH/DECODE/READ/CALC/WAIT/STORE/SHOW.
- It latches and decodes the 16-bit instruction word and drives memory addresses, opcode and immediate.
- It waits on the memory read/stored handshakes and applies per-opcode ALU wait and display hold times.
- It sits between the switch/button inputs and the memory bank, ALU and display.

---
 rtl/cpu_control_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// Mini-CPU main sequencer: walks each instruction through OFF..SHOW, decodes the
// instruction word and times the memory handshakes, ALU wait and display hold.
module cpu_control_unit #(
    parameter int unsigned MUL_WAIT    = 4,
    parameter int unsigned SHOW_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power,
    input  logic        go,
    input  logic [15:0] instruction,
    input  logic        read,
    input  logic        stored,
    output logic [2:0]  stateCPU,
    output logic [2:0]  opcode,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  addr3,
    output logic [15:0] immediate,
    output logic        busy,
    output logic        err,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        StOff    = 3'b000,
        StFetch  = 3'b001,
        StDecode = 3'b010,
        StRead   = 3'b011,
        StCalc   = 3'b100,
        StWait   = 3'b101,
        StStore  = 3'b110,
        StShow   = 3'b111
    } state_e;

    localparam logic [2:0] OpLoad    = 3'b000;
    localparam logic [2:0] OpAdd     = 3'b001;
    localparam logic [2:0] OpAddi    = 3'b010;
    localparam logic [2:0] OpSub     = 3'b011;
    localparam logic [2:0] OpSubi    = 3'b100;
    localparam logic [2:0] OpMul     = 3'b101;
    localparam logic [2:0] OpClear   = 3'b110;
    localparam logic [2:0] OpDisplay = 3'b111;

    // Counter value on the last cycle of each timed state (counter starts at 0 on entry).
    localparam logic [CNT_W-1:0] MulLast     = CNT_W'(MUL_WAIT - 1);
    localparam logic [CNT_W-1:0] ShowLast    = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       instr_q, instr_d;
    logic              go_q;
    logic              go_edge;
    logic [2:0]        op_q, op_d;
    logic [3:0]        a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [15:0]       imm_q, imm_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    assign go_edge = go & ~go_q;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        op_d    = op_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        imm_d   = imm_q;
        done_d  = 1'b0;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        if (!power) begin
            state_d = StOff;
            op_d    = '0;
            a1_d    = '0;
            a2_d    = '0;
            a3_d    = '0;
            imm_d   = '0;
        end else begin
            case (state_q)
                StOff: state_d = StFetch;
                StFetch: begin
                    if (go_edge) begin
                        instr_d = instruction;
                        err_d   = 1'b0;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    op_d  = instr_q[15:13];
                    a1_d  = '0;
                    a2_d  = '0;
                    a3_d  = '0;
                    imm_d = '0;
                    case (instr_q[15:13])
                        OpLoad: begin
                            a1_d  = instr_q[12:9];
                            imm_d = {{7{instr_q[8]}}, instr_q[8:0]};
                        end
                        OpAdd, OpSub: begin
                            a3_d = instr_q[12:9];
                            a1_d = instr_q[8:5];
                            a2_d = instr_q[4:1];
                        end
                        OpAddi, OpSubi, OpMul: begin
                            a2_d  = instr_q[12:9];
                            a1_d  = instr_q[8:5];
                            imm_d = {{11{instr_q[4]}}, instr_q[4:0]};
                        end
                        OpDisplay: a1_d = instr_q[12:9];
                        default: ;
                    endcase
                    case (instr_q[15:13])
                        OpLoad:  state_d = StCalc;
                        OpClear: state_d = StStore;
                        default: state_d = StRead;
                    endcase
                end
                StRead: begin
                    // A handshake on the timeout cycle still wins.
                    if (read) begin
                        state_d = (op_q == OpDisplay) ? StShow : StCalc;
                    end else if (cnt_q == TimeoutLast) begin
                        err_d   = 1'b1;
                        state_d = StFetch;
                    end
                end
                StCalc: state_d = StWait;
                StWait: begin
                    if (op_q != OpMul || cnt_q == MulLast) state_d = StStore;
                end
                StStore: begin
                    if (stored) begin
                        state_d = StShow;
                    end else if (cnt_q == TimeoutLast) begin
                        err_d   = 1'b1;
                        state_d = StFetch;
                    end
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        state_d = StFetch;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StOff;
            endcase
        end

        if (state_d != state_q) cnt_d = '0;
        busy_d = !(state_d == StOff || state_d == StFetch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
            cnt_q   <= '0;
            instr_q <= '0;
            go_q    <= 1'b0;
            op_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            imm_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            go_q    <= go;
            op_q    <= op_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            imm_q   <= imm_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign stateCPU   = state_q;
    assign opcode     = op_q;
    assign addr1      = a1_q;
    assign addr2      = a2_q;
    assign addr3      = a3_q;
    assign immediate  = imm_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign instr_done = done_q;

endmodule
